branch_resolve_ctrl: RTL and testbench

Sequences conditional-branch resolution in the MIPS32 single-cycle core. Accepts one branch at a time from decode over a valid/ready handshake and registers the operands. It evaluates the compare for opcodes 0x08-0x0D, then drives a held PC-redirect request to fetch, plus a one-cycle flush pulse, until fetch acknowledges. It also supports a kill input for exceptions.

---
 rtl/branch_resolve_ctrl.sv | 157 +++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: conditional-branch resolution sequencer for the MIPS32 core.
// Accepts one branch from decode, compares the registered operands (opcodes 0x08-0x0D,
// unsigned), reports the outcome for one cycle and, for taken branches, holds a
// redirect request to fetch (with a one-cycle flush) until fetch acknowledges.
// Optional feature macro: BRANCH_STATS_EN enables saturating taken/not-taken counters;
// without it both counter outputs are tied to 0.
module branch_resolve_ctrl #(
  parameter int PC_WIDTH   = 32,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  br_valid,
  output logic                  br_ready,
  input  logic [31:0]           br_ir,
  input  logic [PC_WIDTH-1:0]   br_pc,
  input  logic [31:0]           br_a,
  input  logic [31:0]           br_b,
  input  logic                  kill,
  output logic                  resolve_valid,
  output logic                  resolve_taken,
  output logic                  illegal_op,
  output logic                  redirect_valid,
  output logic [PC_WIDTH-1:0]   redirect_pc,
  input  logic                  redirect_ready,
  output logic                  flush,
  output logic [STAT_WIDTH-1:0] taken_cnt,
  output logic [STAT_WIDTH-1:0] nottaken_cnt
);

  typedef enum logic [1:0] {IDLE, EVAL, REDIRECT} state_t;

  state_t              state;
  logic [5:0]          op_r;
  logic [15:0]         imm_r;
  logic [PC_WIDTH-1:0] pc_r;
  logic [31:0]         a_r;
  logic [31:0]         b_r;

  logic                taken_c;
  logic                illegal_c;
  logic [PC_WIDTH-1:0] off_c;
  logic [PC_WIDTH-1:0] target_c;

  // Register-field bits between opcode and immediate carry nothing for branches.
  logic unused_ir;
  assign unused_ir = ^br_ir[25:16];

  // Outcome of the captured branch: unsigned compare selected by opcode.
  always_comb begin
    taken_c   = 1'b0;
    illegal_c = 1'b0;
    case (op_r)
      6'h08:   taken_c = (a_r == b_r);
      6'h09:   taken_c = (a_r != b_r);
      6'h0A:   taken_c = (a_r >= b_r);
      6'h0B:   taken_c = (a_r >  b_r);
      6'h0C:   taken_c = (a_r <= b_r);
      6'h0D:   taken_c = (a_r <  b_r);
      default: illegal_c = 1'b1;
    endcase
  end

  // Target = pc + 4 + sext(imm) * 4, modulo 2^PC_WIDTH.
  assign off_c    = PC_WIDTH'($signed({imm_r, 2'b00}));
  assign target_c = pc_r + PC_WIDTH'(4) + off_c;

  // Control FSM with registered outputs; kill overrides every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      br_ready       <= 1'b1;
      op_r           <= '0;
      imm_r          <= '0;
      pc_r           <= '0;
      a_r            <= '0;
      b_r            <= '0;
      resolve_valid  <= 1'b0;
      resolve_taken  <= 1'b0;
      illegal_op     <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
    end else begin
      resolve_valid <= 1'b0;
      resolve_taken <= 1'b0;
      illegal_op    <= 1'b0;
      flush         <= 1'b0;
      if (kill) begin
        state          <= IDLE;
        br_ready       <= 1'b1;
        redirect_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (br_valid) begin
              op_r     <= br_ir[31:26];
              imm_r    <= br_ir[15:0];
              pc_r     <= br_pc;
              a_r      <= br_a;
              b_r      <= br_b;
              br_ready <= 1'b0;
              state    <= EVAL;
            end
          end
          EVAL: begin
            resolve_valid <= 1'b1;
            resolve_taken <= taken_c;
            illegal_op    <= illegal_c;
            if (taken_c) begin
              redirect_valid <= 1'b1;
              redirect_pc    <= target_c;
              flush          <= 1'b1;
              state          <= REDIRECT;
            end else begin
              br_ready <= 1'b1;
              state    <= IDLE;
            end
          end
          REDIRECT: begin
            if (redirect_ready) begin
              redirect_valid <= 1'b0;
              br_ready       <= 1'b1;
              state          <= IDLE;
            end
          end
          default: begin
            br_ready <= 1'b1;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef BRANCH_STATS_EN
  localparam logic [STAT_WIDTH-1:0] CNT_MAX = '1;

  // Saturating outcome counters, bumped on the edge that raises resolve_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_cnt    <= '0;
      nottaken_cnt <= '0;
    end else if (state == EVAL && !kill) begin
      if (taken_c) begin
        if (taken_cnt != CNT_MAX) taken_cnt <= taken_cnt + STAT_WIDTH'(1);
      end else begin
        if (nottaken_cnt != CNT_MAX) nottaken_cnt <= nottaken_cnt + STAT_WIDTH'(1);
      end
    end
  end
`else
  assign taken_cnt    = '0;
  assign nottaken_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Testbench for branch_resolve_ctrl: driver issues directed and random branches and
// pushes expected outcomes into a queue; an independent monitor pops and compares
// whenever the DUT presents resolve_valid, and checks the redirect/flush protocol.
module tb_branch_resolve_ctrl;

  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          br_valid = 1'b0;
  logic          br_ready;
  logic [31:0]   br_ir = '0;
  logic [31:0]   br_pc = '0;
  logic [31:0]   br_a = '0;
  logic [31:0]   br_b = '0;
  logic          kill = 1'b0;
  logic          resolve_valid;
  logic          resolve_taken;
  logic          illegal_op;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          redirect_ready = 1'b0;
  logic          flush;
  logic [SW-1:0] taken_cnt;
  logic [SW-1:0] nottaken_cnt;

  branch_resolve_ctrl #(.PC_WIDTH(32), .STAT_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .br_valid(br_valid), .br_ready(br_ready), .br_ir(br_ir), .br_pc(br_pc),
    .br_a(br_a), .br_b(br_b), .kill(kill),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .illegal_op(illegal_op),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .flush(flush),
    .taken_cnt(taken_cnt), .nottaken_cnt(nottaken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          tk;
    bit          il;
    logic [31:0] tgt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   tk_m = 0;
  int   nt_m = 0;
  int   txn = 0;
  logic [31:0] cur_tgt = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour straight from the branch rules.
  function automatic exp_t model(input logic [31:0] ir, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint t;
    e.tk = 1'b0;
    e.il = 1'b0;
    case (ir[31:26])
      6'h08:   e.tk = (a == b);
      6'h09:   e.tk = (a != b);
      6'h0A:   e.tk = (a >= b);
      6'h0B:   e.tk = (a >  b);
      6'h0C:   e.tk = (a <= b);
      6'h0D:   e.tk = (a <  b);
      default: e.il = 1'b1;
    endcase
    t = longint'(pc) + 64'sd4 + 64'sd4 * longint'($signed(ir[15:0]));
    e.tgt = t[31:0];
    return e;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= (1 << SW) - 1) ? v : v + 1;
  endfunction

  // Monitor: compares every resolve against the scoreboard and checks redirect protocol.
  initial begin
    exp_t e;
    bit   prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      if (resolve_valid) begin
        if (q.size() == 0) begin
          check("unexpected_resolve", 32'(resolve_valid), 32'd0);
        end else begin
          e = q.pop_front();
          if (e.tk) tk_m = sat_inc(tk_m);
          else      nt_m = sat_inc(nt_m);
          cur_tgt = e.tgt;
          check("resolve_taken", 32'(resolve_taken), 32'(e.tk));
          check("illegal_op", 32'(illegal_op), 32'(e.il));
          check("redirect_on_resolve", 32'(redirect_valid), 32'(e.tk));
`ifdef BRANCH_STATS_EN
          check("taken_cnt", 32'(taken_cnt), 32'(tk_m));
          check("nottaken_cnt", 32'(nottaken_cnt), 32'(nt_m));
`else
          check("taken_cnt", 32'(taken_cnt), 32'd0);
          check("nottaken_cnt", 32'(nottaken_cnt), 32'd0);
`endif
        end
      end else if (illegal_op) begin
        check("illegal_without_resolve", 32'(illegal_op), 32'd0);
      end
      if (redirect_valid) begin
        check("redirect_pc", redirect_pc, cur_tgt);
        check("flush_first_only", 32'(flush), 32'(!prev_rv));
      end else if (flush) begin
        check("flush_without_redirect", 32'(flush), 32'd0);
      end
      prev_rv = redirect_valid;
    end
  end

  // Issue one branch. Called at a negedge; returns at a negedge.
  task automatic do_branch(input logic [31:0] ir, input logic [31:0] pc,
                           input logic [31:0] a, input logic [31:0] b,
                           input bit k_acc, input bit k_eval,
                           input int ack_dly, input bit k_ack);
    exp_t e;
    int   w;
    e = model(ir, pc, a, b);
    w = 0;
    while (!br_ready && w < 8) begin
      @(negedge clk);
      w++;
    end
    if (!br_ready) check("br_ready_timeout", 32'(br_ready), 32'd1);
    $display("txn %0d: op=0x%02h a=0x%08h b=0x%08h pc=0x%08h imm=0x%04h exp_taken=%0d exp_tgt=0x%08h kill(acc/eval/ack)=%0d/%0d/%0d",
             txn, ir[31:26], a, b, pc, ir[15:0], e.tk, e.tgt, k_acc, k_eval, k_ack);
    txn++;
    br_valid = 1'b1;
    br_ir = ir; br_pc = pc; br_a = a; br_b = b;
    kill = k_acc;
    redirect_ready = 1'($urandom_range(0, 1));
    if (!k_acc && !k_eval) q.push_back(e);
    @(negedge clk);
    br_valid = 1'b0;
    kill = 1'b0;
    br_ir = $urandom; br_pc = $urandom; br_a = $urandom; br_b = $urandom;
    if (k_acc) begin
      check("ready_after_kill_accept", 32'(br_ready), 32'd1);
      return;
    end
    check("busy_in_eval", 32'(br_ready), 32'd0);
    if (k_eval) begin
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check("ready_after_kill_eval", 32'(br_ready), 32'd1);
      check("no_redirect_after_kill_eval", 32'(redirect_valid), 32'd0);
      return;
    end
    redirect_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    if (!e.tk) begin
      check("ready_after_not_taken", 32'(br_ready), 32'd1);
      return;
    end
    for (int i = 0; i < ack_dly; i++) begin
      redirect_ready = 1'b0;
      @(negedge clk);
      check("redirect_held", 32'(redirect_valid), 32'd1);
      check("busy_in_redirect", 32'(br_ready), 32'd0);
    end
    redirect_ready = 1'b1;
    kill = k_ack;
    @(negedge clk);
    redirect_ready = 1'b0;
    kill = 1'b0;
    check("redirect_dropped", 32'(redirect_valid), 32'd0);
    check("ready_after_ack", 32'(br_ready), 32'd1);
  endtask

  function automatic logic [31:0] mk_ir(input logic [5:0] op, input logic [15:0] imm);
    logic [9:0] mid;
    mid = 10'($urandom);
    return {op, mid, imm};
  endfunction

  initial begin
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
    #23 rst = 1'b0;
    @(negedge clk);
    check("reset_br_ready", 32'(br_ready), 32'd1);
    check("reset_resolve_valid", 32'(resolve_valid), 32'd0);
    check("reset_redirect_valid", 32'(redirect_valid), 32'd0);
    check("reset_redirect_pc", redirect_pc, 32'd0);
    check("reset_flush", 32'(flush), 32'd0);
    check("reset_counts", 32'({taken_cnt, nottaken_cnt}), 32'd0);

    // Directed cases.
    do_branch(mk_ir(6'h08, 16'h0003), 32'h100, 32'd5, 32'd5, 0, 0, 3, 0);
    do_branch(mk_ir(6'h0D, 16'h0010), 32'h400, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0);
    do_branch(mk_ir(6'h0A, 16'hFFFE), 32'h200, 32'd7, 32'd7, 0, 0, 1, 0);
    do_branch(mk_ir(6'h08, 16'h0000), 32'hFFFF_FFFC, 32'd9, 32'd9, 0, 0, 0, 0);
    do_branch(mk_ir(6'h23, 16'h0004), 32'h300, 32'd1, 32'd1, 0, 0, 0, 0);
    do_branch(mk_ir(6'h09, 16'h0008), 32'h500, 32'd1, 32'd2, 0, 0, 1, 1);
    do_branch(mk_ir(6'h08, 16'h0008), 32'h600, 32'd3, 32'd3, 1, 0, 0, 0);
    do_branch(mk_ir(6'h0B, 16'h0008), 32'h700, 32'd4, 32'd3, 0, 1, 0, 0);
`ifdef BRANCH_STATS_EN
    for (int i = 0; i < 17; i++)
      do_branch(mk_ir(6'h0C, 16'h0001), 32'h800, 32'd1, 32'd2, 0, 0, 0, 0);
    @(negedge clk);
    check("taken_saturated", 32'(taken_cnt), 32'd15);
`endif

    // Async reset in the middle of a redirect.
    e = model(mk_ir(6'h08, 16'h0020), 32'h900, 32'd0, 32'd0);
    q.push_back(e);
    br_valid = 1'b1; br_ir = mk_ir(6'h08, 16'h0020); br_pc = 32'h900; br_a = 0; br_b = 0;
    redirect_ready = 1'b0;
    @(negedge clk);
    br_valid = 1'b0;
    @(negedge clk);
    check("redirect_before_reset", 32'(redirect_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_redirect", 32'(redirect_valid), 32'd0);
    check("async_reset_ready", 32'(br_ready), 32'd1);
    check("async_reset_counts", 32'({taken_cnt, nottaken_cnt}), 32'd0);
    tk_m = 0;
    nt_m = 0;
    #1 rst = 1'b0;
    @(negedge clk);

    // Random traffic.
    for (int n = 0; n < 80; n++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'(8 + $urandom_range(0, 5));
      a = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 3));
      b = ($urandom_range(0, 2) == 0) ? a : 32'($urandom_range(0, 3));
      do_branch(mk_ir(op, 16'($urandom)), {$urandom} & 32'hFFFF_FFFC, a, b,
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 3), $urandom_range(0, 7) == 0);
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
